pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 The block SHALL be parameterised as follows:
- ALUCTRL_W, default 4: ALU control width.
- REG_W, default 4: register index width.
- PC_IDX, default 15: index whose write redirects the PC.
- LR_IDX, default 14: link register index.

REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-low. Ports, clock and reset first:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- OP  in  2  instruction class from Decode.
- FUNCT  in  6  instruction function field from Decode.
- COND  in  4  condition field from Decode.
- RD  in  REG_W  destination register from Decode.
- ALUFlags  in  4  NZCV produced by the ALU in Execute.
- StallE  in  1  hold the D->E control register.
- FlushE  in  1  load a bubble into Execute.
- RegSrcD  out  2  register-source select, combinational, Decode stage.
- ImmSrcD  out  2  immediate-extend select, combinational, Decode stage.
- ALUControlE  out  ALUCTRL_W  ALU operation in Execute.
- ALUSrcE  out  1  ALU B-operand select in Execute.
- CondExE  out  1  condition passed in Execute.
- BranchTakenE  out  1  conditional branch resolved taken in Execute.
- RegWriteM  out  1  register write enable, Memory stage.
- MemWriteM  out  1  data-memory write enable, Memory stage.
- RegWriteW  out  1  register write enable, Writeback stage.
- MemtoRegW  out  1  writeback-from-memory select, Writeback stage.
- PCSrcW  out  1  PC redirect in Writeback.
- LinkW  out  1  writeback targets LR_IDX.
- Flags  out  4  architectural NZCV register.

Function
REQ-003 Decode SHALL be combinational from OP, FUNCT and COND.

REQ-004 Data processing (OP=00) SHALL decode as follows:
- cmd=FUNCT[4:1], S=FUNCT[0], ALUSrc=FUNCT[5].
- ALUControl: AND 0000, SUB 0010, ADD 0100, ORR 1100, MOV 1101; CMP (1010) SHALL map to 0010.
- RegWrite=1 except CMP.
- FlagWrite=S|CMP.

REQ-005 Memory (OP=01) SHALL decode as follows:
- ALUControl=0100, ALUSrc=1, ImmSrc=01.
- FUNCT[0]=1 (LDR): RegWrite=1, MemtoReg=1, RegSrc=00.
- FUNCT[0]=0 (STR): MemWrite=1, RegSrc=10.

REQ-006 Branch (OP=10) SHALL decode as follows:
- FUNCT[5:4]=10 (B): Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, ALUControl=0100.
- FUNCT[5:4]=11 (BL): as B, plus RegWrite=1 and Link=1.
- FUNCT[5:4]=00 (BX): Branch=1, ALUControl=1101.

REQ-007 Decode SHALL force all of RegWrite, MemWrite, Branch and FlagWrite to 0 for:
- COND=1111;
- OP=11;
- any undefined cmd.

REQ-008 PCWrite SHALL be Branch | (RegWrite & RD==PC_IDX & ~Link).

REQ-009 The D->E register SHALL behave as follows:
- It captures the control bundle and COND each cycle.
- StallE=1 SHALL hold the register.
- FlushE=1 SHALL clear all write/branch/flag-write bits.
- FlushE SHALL take priority over StallE.

REQ-010 CondExE SHALL be combinational from CondE and Flags, with the full ARM table:
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
- HI C&!Z, LS !C|Z.
- GE N==V, LT N!=V.
- GT !Z&(N==V), LE Z|(N!=V).
- AL 1, 1111 0.

REQ-011 Flags SHALL load ALUFlags at the edge ending an Execute cycle with FlagWriteE & CondExE; otherwise Flags SHALL hold.

REQ-012 An instruction directly following a flag-setting instruction SHALL evaluate its condition against the updated Flags.

REQ-013 BranchTakenE SHALL be BranchE & CondExE.

REQ-014 The E->M register SHALL capture RegWrite, MemWrite and PCWrite each gated by CondExE, plus MemtoReg and Link ungated.

REQ-015 The M->W register SHALL pass RegWrite, MemtoReg, PCWrite (to PCSrcW) and Link unchanged.

REQ-016 Latency SHALL be one cycle per stage boundary:
- a Decode-cycle control bit appears in E at N+1;
- in M at N+2;
- in W at N+3.

Reset
REQ-017 While RESET=0 at a rising edge, every pipeline register and Flags SHALL clear to 0. This SHALL hold even with StallE=1 and mid-instruction.

REQ-018 After a reset edge, all E/M/W outputs SHALL read 0 until valid instructions propagate.

REQ-019 Decode-stage outputs (RegSrcD, ImmSrcD) SHALL remain combinational and SHALL be unaffected by reset.

Verification
REQ-020 ADD, S=0 (OP=00, FUNCT=001000, COND=1110, RD=3) -> ALUControlE=0100 at N+1, RegWriteM=1 at N+2, RegWriteW=1 at N+3, Flags unchanged.

REQ-021 CMP with ALUFlags=0100 followed by BEQ -> Flags=0100 after CMP's E cycle; BEQ gives CondExE=1, BranchTakenE=1, PCSrcW=1 three cycles after its Decode cycle.

REQ-022 Flags=1000 (N=1, V=0), GE then LT data-processing ops -> GE gives CondExE=0 and RegWriteM=0; LT gives CondExE=1 and RegWriteM=1.

REQ-023 BL -> RegWriteW=1, LinkW=1, PCSrcW=1.

REQ-024 MOV with RD=15 -> PCSrcW=1, LinkW=0.

REQ-025 STR with StallE=1 for 2 cycles -> ALUControlE=0100 held; MemWriteM=1 exactly once. With StallE=1 and FlushE=1 together -> bubble: MemWriteM=0.

REQ-026 Reset and COND=1111 cases:
- RESET=0 asserted while an LDR is in M -> RegWriteW=0, MemtoRegW=0, Flags=0000 on the following cycle.
- COND=1111 -> no write in any stage.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit -- control path for a 4-stage (D/E/M/W) ARM-style pipeline.
//
// Decode is purely combinational from OP/FUNCT/COND. The decoded control
// bundle then moves through D->E, E->M and M->W registers. The E stage holds
// the condition check against the architectural NZCV register (Flags).
//
// Ports
//   CLK, RESET           clock, synchronous active-low reset
//   OP, FUNCT, COND, RD  instruction fields from Decode
//   ALUFlags             NZCV result from the ALU in Execute
//   StallE, FlushE       hold / bubble the D->E register (flush wins)
//   RegSrcD, ImmSrcD     Decode-stage operand selects (combinational)
//   ALUControlE, ALUSrcE, CondExE, BranchTakenE   Execute-stage controls
//   RegWriteM, MemWriteM                          Memory-stage enables
//   RegWriteW, MemtoRegW, PCSrcW, LinkW           Writeback-stage controls
//   Flags                architectural NZCV register {N,Z,C,V}
module pipe_ctrl_unit #(
  parameter int ALUCTRL_W = 4,
  parameter int REG_W     = 4,
  parameter int PC_IDX    = 15,
  parameter int LR_IDX    = 14
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [1:0]           OP,
  input  logic [5:0]           FUNCT,
  input  logic [3:0]           COND,
  input  logic [REG_W-1:0]     RD,
  input  logic [3:0]           ALUFlags,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 CondExE,
  output logic                 BranchTakenE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic                 LinkW,
  output logic [3:0]           Flags
);

  localparam logic [ALUCTRL_W-1:0] AC_AND = ALUCTRL_W'(4'b0000);
  localparam logic [ALUCTRL_W-1:0] AC_SUB = ALUCTRL_W'(4'b0010);
  localparam logic [ALUCTRL_W-1:0] AC_ADD = ALUCTRL_W'(4'b0100);
  localparam logic [ALUCTRL_W-1:0] AC_ORR = ALUCTRL_W'(4'b1100);
  localparam logic [ALUCTRL_W-1:0] AC_MOV = ALUCTRL_W'(4'b1101);

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 branch;
    logic                 flag_write;
    logic                 pc_write;
    logic                 link;
    logic                 alu_src;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [3:0]           cond;
  } ctrl_e_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic pc_write;
    logic mem_to_reg;
    logic link;
  } ctrl_mw_t;

  ctrl_e_t  dec;
  logic     dec_undef;
  logic [1:0] reg_src, imm_src;
  logic [REG_W-1:0] dec_dest;

  ctrl_e_t  ctrl_e_d, ctrl_e_q;
  ctrl_mw_t ctrl_m_d, ctrl_m_q;
  ctrl_mw_t ctrl_w_d, ctrl_w_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex;

  // ---------------- Decode ----------------
  always_comb begin
    dec        = '0;
    dec_undef  = 1'b0;
    reg_src    = 2'b00;
    imm_src    = 2'b00;
    dec.cond   = COND;
    case (OP)
      2'b00: begin
        dec.alu_src    = FUNCT[5];
        dec.reg_write  = 1'b1;
        dec.flag_write = FUNCT[0];
        case (FUNCT[4:1])
          4'b0000: dec.alu_ctrl = AC_AND;
          4'b0010: dec.alu_ctrl = AC_SUB;
          4'b0100: dec.alu_ctrl = AC_ADD;
          4'b1100: dec.alu_ctrl = AC_ORR;
          4'b1101: dec.alu_ctrl = AC_MOV;
          4'b1010: begin            // CMP: subtract, flags only
            dec.alu_ctrl   = AC_SUB;
            dec.reg_write  = 1'b0;
            dec.flag_write = 1'b1;
          end
          default: dec_undef = 1'b1;
        endcase
      end
      2'b01: begin
        dec.alu_ctrl = AC_ADD;
        dec.alu_src  = 1'b1;
        imm_src      = 2'b01;
        if (FUNCT[0]) begin         // LDR
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 1'b1;
        end else begin              // STR reads the store data via Rd
          dec.mem_write = 1'b1;
          reg_src       = 2'b10;
        end
      end
      2'b10: begin
        case (FUNCT[5:4])
          2'b10, 2'b11: begin       // B / BL
            dec.branch   = 1'b1;
            dec.alu_src  = 1'b1;
            dec.alu_ctrl = AC_ADD;
            imm_src      = 2'b10;
            reg_src      = 2'b01;
            if (FUNCT[4]) begin
              dec.reg_write = 1'b1;
              dec.link      = 1'b1;
            end
          end
          2'b00: begin              // BX: pass Rm through the ALU
            dec.branch   = 1'b1;
            dec.alu_ctrl = AC_MOV;
          end
          default: dec_undef = 1'b1;
        endcase
      end
      default: dec_undef = 1'b1;
    endcase

    // Never-execute and undefined encodings must not write anything.
    if (dec_undef || COND == 4'b1111) begin
      dec.reg_write  = 1'b0;
      dec.mem_write  = 1'b0;
      dec.branch     = 1'b0;
      dec.flag_write = 1'b0;
      dec.link       = 1'b0;
    end

    // A linking write lands in LR, so only a real write to PC redirects.
    dec_dest     = dec.link ? REG_W'(LR_IDX) : RD;
    dec.pc_write = dec.branch | (dec.reg_write & (dec_dest == REG_W'(PC_IDX)));
  end

  // ---------------- Condition check ----------------
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (ctrl_e_q.cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = !z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = !c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = !n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = !v;
      4'h8: cond_ex = c & !z;
      4'h9: cond_ex = !c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = !z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ---------------- Next-state ----------------
  always_comb begin
    ctrl_e_d = ctrl_e_q;
    if (FlushE)       ctrl_e_d = '0;
    else if (!StallE) ctrl_e_d = dec;
  end

  // While E is stalled the instruction there re-executes next cycle, so
  // nothing leaves E (bubble into M) and Flags are not committed yet.
  always_comb begin
    ctrl_m_d = '0;
    if (!StallE) begin
      ctrl_m_d.reg_write  = ctrl_e_q.reg_write & cond_ex;
      ctrl_m_d.mem_write  = ctrl_e_q.mem_write & cond_ex;
      ctrl_m_d.pc_write   = ctrl_e_q.pc_write  & cond_ex;
      ctrl_m_d.mem_to_reg = ctrl_e_q.mem_to_reg;
      ctrl_m_d.link       = ctrl_e_q.link;
    end
  end

  always_comb begin
    ctrl_w_d = ctrl_m_q;
  end

  always_comb begin
    flags_d = flags_q;
    if (!StallE && ctrl_e_q.flag_write && cond_ex) flags_d = ALUFlags;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
      flags_q  <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
      flags_q  <= flags_d;
    end
  end

  // ---------------- Outputs ----------------
  assign RegSrcD      = reg_src;
  assign ImmSrcD      = imm_src;
  assign ALUControlE  = ctrl_e_q.alu_ctrl;
  assign ALUSrcE      = ctrl_e_q.alu_src;
  assign CondExE      = cond_ex;
  assign BranchTakenE = ctrl_e_q.branch & cond_ex;
  assign RegWriteM    = ctrl_m_q.reg_write;
  assign MemWriteM    = ctrl_m_q.mem_write;
  assign RegWriteW    = ctrl_w_q.reg_write;
  assign MemtoRegW    = ctrl_w_q.mem_to_reg;
  assign PCSrcW       = ctrl_w_q.pc_write;
  assign LinkW        = ctrl_w_q.link;
  assign Flags        = flags_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: a vector table walked through all four
// stages, then hand-written sequences for flag forwarding, stall/flush and
// mid-flight reset.
module tb_pipe_ctrl_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] OP;
  logic [5:0] FUNCT;
  logic [3:0] COND;
  logic [3:0] RD;
  logic [3:0] ALUFlags;
  logic       StallE, FlushE;
  logic [1:0] RegSrcD, ImmSrcD;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, CondExE, BranchTakenE, RegWriteM, MemWriteM;
  logic       RegWriteW, MemtoRegW, PCSrcW, LinkW;
  logic [3:0] Flags;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pipe_ctrl_unit dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .FUNCT(FUNCT), .COND(COND), .RD(RD),
    .ALUFlags(ALUFlags), .StallE(StallE), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .LinkW(LinkW), .Flags(Flags)
  );

  typedef struct {
    logic [1:0] op;  logic [5:0] funct; logic [3:0] cond; logic [3:0] rd;
    logic [1:0] rsrc; logic [1:0] isrc; logic [3:0] aluc; logic alus;
    logic condex; logic bt; logic rwm; logic mwm; logic rww; logic m2r;
    logic pcs; logic lnk; logic [3:0] flg;
  } vec_t;

  vec_t vecs[20];
  int   mw_cnt;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] cond, input logic [3:0] rd);
    OP = op; FUNCT = funct; COND = cond; RD = rd;
  endtask

  task automatic bubble;
    drive(2'b11, 6'b000000, 4'b1110, 4'd0);
  endtask

  task automatic do_reset;
    RESET = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    bubble();
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    //          op     funct      cond    rd  rsrc  isrc  aluc   als cx bt rwm mwm rww m2r pcs lnk flg
    vecs[0]  = '{2'b00,6'b001000,4'b1110,4'd3, 2'b00,2'b00,4'b0100,0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b0000}; // ADD
    vecs[1]  = '{2'b00,6'b100101,4'b1110,4'd2, 2'b00,2'b00,4'b0010,1, 1, 0, 1, 0, 1, 0, 0, 0, 4'b1111}; // SUBS imm
    vecs[2]  = '{2'b00,6'b000000,4'b1110,4'd1, 2'b00,2'b00,4'b0000,0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b0000}; // AND
    vecs[3]  = '{2'b00,6'b011000,4'b1110,4'd1, 2'b00,2'b00,4'b1100,0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b0000}; // ORR
    vecs[4]  = '{2'b00,6'b011010,4'b1110,4'd15,2'b00,2'b00,4'b1101,0, 1, 0, 1, 0, 1, 0, 1, 0, 4'b0000}; // MOV pc
    vecs[5]  = '{2'b00,6'b010101,4'b1110,4'd0, 2'b00,2'b00,4'b0010,0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1111}; // CMP
    vecs[6]  = '{2'b01,6'b000001,4'b1110,4'd4, 2'b00,2'b01,4'b0100,1, 1, 0, 1, 0, 1, 1, 0, 0, 4'b0000}; // LDR
    vecs[7]  = '{2'b01,6'b000000,4'b1110,4'd4, 2'b10,2'b01,4'b0100,1, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0000}; // STR
    vecs[8]  = '{2'b10,6'b100000,4'b1110,4'd0, 2'b01,2'b10,4'b0100,1, 1, 1, 0, 0, 0, 0, 1, 0, 4'b0000}; // B
    vecs[9]  = '{2'b10,6'b110000,4'b1110,4'd0, 2'b01,2'b10,4'b0100,1, 1, 1, 1, 0, 1, 0, 1, 1, 4'b0000}; // BL
    vecs[10] = '{2'b10,6'b000000,4'b1110,4'd0, 2'b00,2'b00,4'b1101,0, 1, 1, 0, 0, 0, 0, 1, 0, 4'b0000}; // BX
    vecs[11] = '{2'b10,6'b100000,4'b0000,4'd0, 2'b01,2'b10,4'b0100,1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000}; // BEQ, Z=0
    vecs[12] = '{2'b00,6'b001000,4'b1111,4'd15,2'b00,2'b00,4'b0100,0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000}; // cond NV
    vecs[13] = '{2'b11,6'b001000,4'b1110,4'd15,2'b00,2'b00,4'b0000,0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000}; // OP=11
    vecs[14] = '{2'b00,6'b000010,4'b1110,4'd15,2'b00,2'b00,4'b0000,0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000}; // undef cmd
    vecs[15] = '{2'b00,6'b001000,4'b0000,4'd15,2'b00,2'b00,4'b0100,0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000}; // ADDEQ pc
    vecs[16] = '{2'b00,6'b001000,4'b0101,4'd3, 2'b00,2'b00,4'b0100,0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b0000}; // PL
    vecs[17] = '{2'b00,6'b001000,4'b1001,4'd3, 2'b00,2'b00,4'b0100,0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b0000}; // LS
    vecs[18] = '{2'b00,6'b001000,4'b1100,4'd3, 2'b00,2'b00,4'b0100,0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b0000}; // GT
    vecs[19] = '{2'b00,6'b001000,4'b0100,4'd3, 2'b00,2'b00,4'b0100,0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000}; // MI

    ALUFlags = 4'b0000;
    do_reset();
    // reset state: every E/M/W output and Flags clear
    chk("rst_aluc", 8'(ALUControlE), 8'h0);
    chk("rst_bundle", {ALUSrcE, CondExE, BranchTakenE, RegWriteM, MemWriteM,
                       RegWriteW, MemtoRegW, PCSrcW}, 8'h0);
    chk("rst_link", 8'(LinkW), 8'h0);
    chk("rst_flags", 8'(Flags), 8'h0);

    // ---- table: one instruction at a time through D/E/M/W, Flags = 0 ----
    ALUFlags = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      do_reset();
      drive(vecs[i].op, vecs[i].funct, vecs[i].cond, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_regsrcD", i), 8'(RegSrcD), 8'(vecs[i].rsrc));
      chk($sformatf("v%0d_immsrcD", i), 8'(ImmSrcD), 8'(vecs[i].isrc));
      tick();
      bubble();
      chk($sformatf("v%0d_alucE", i), 8'(ALUControlE), 8'(vecs[i].aluc));
      chk($sformatf("v%0d_alusrcE", i), 8'(ALUSrcE), 8'(vecs[i].alus));
      chk($sformatf("v%0d_condexE", i), 8'(CondExE), 8'(vecs[i].condex));
      chk($sformatf("v%0d_btakenE", i), 8'(BranchTakenE), 8'(vecs[i].bt));
      tick();
      chk($sformatf("v%0d_regwrM", i), 8'(RegWriteM), 8'(vecs[i].rwm));
      chk($sformatf("v%0d_memwrM", i), 8'(MemWriteM), 8'(vecs[i].mwm));
      chk($sformatf("v%0d_flags", i), 8'(Flags), 8'(vecs[i].flg));
      tick();
      chk($sformatf("v%0d_regwrW", i), 8'(RegWriteW), 8'(vecs[i].rww));
      chk($sformatf("v%0d_m2rW", i), 8'(MemtoRegW), 8'(vecs[i].m2r));
      chk($sformatf("v%0d_pcsrcW", i), 8'(PCSrcW), 8'(vecs[i].pcs));
      chk($sformatf("v%0d_linkW", i), 8'(LinkW), 8'(vecs[i].lnk));
    end

    // ---- CMP sets Z, BEQ directly after sees it ----
    do_reset();
    ALUFlags = 4'b0100;
    drive(2'b00, 6'b010101, 4'b1110, 4'd0);  // CMP
    tick();
    drive(2'b10, 6'b100000, 4'b0000, 4'd0);  // BEQ
    tick();
    bubble();
    chk("beq_flags", 8'(Flags), 8'h4);
    chk("beq_condex", 8'(CondExE), 8'h1);
    chk("beq_taken", 8'(BranchTakenE), 8'h1);
    tick();
    tick();
    chk("beq_pcsrcW", 8'(PCSrcW), 8'h1);

    // ---- N=1,V=0: GE fails, LT passes ----
    do_reset();
    ALUFlags = 4'b1000;
    drive(2'b00, 6'b010101, 4'b1110, 4'd0);  // CMP -> Flags=1000
    tick();
    drive(2'b00, 6'b001000, 4'b1010, 4'd1);  // ADDGE
    tick();
    chk("ge_flags", 8'(Flags), 8'h8);
    chk("ge_condex", 8'(CondExE), 8'h0);
    drive(2'b00, 6'b001000, 4'b1011, 4'd2);  // ADDLT
    tick();
    bubble();
    chk("ge_regwrM", 8'(RegWriteM), 8'h0);
    chk("lt_condex", 8'(CondExE), 8'h1);
    tick();
    chk("lt_regwrM", 8'(RegWriteM), 8'h1);

    // ---- STR held two cycles by StallE: one memory write ----
    do_reset();
    mw_cnt = 0;
    drive(2'b01, 6'b000000, 4'b1110, 4'd4);  // STR
    tick();
    bubble();
    StallE = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("stall%0d_aluc", k), 8'(ALUControlE), 8'h4);
      mw_cnt += int'(MemWriteM);
    end
    StallE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      mw_cnt += int'(MemWriteM);
    end
    chk("stall_memwr_once", 8'(mw_cnt), 8'h1);

    // ---- StallE and FlushE together: bubble ----
    do_reset();
    drive(2'b01, 6'b000000, 4'b1110, 4'd4);  // STR
    tick();
    bubble();
    StallE = 1'b1; FlushE = 1'b1;
    tick();
    StallE = 1'b0; FlushE = 1'b0;
    chk("flush_aluc", 8'(ALUControlE), 8'h0);
    mw_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      mw_cnt += int'(MemWriteM);
    end
    chk("flush_memwr", 8'(mw_cnt), 8'h0);

    // ---- reset while LDR in M, with Flags non-zero and StallE high ----
    do_reset();
    ALUFlags = 4'b0110;
    drive(2'b00, 6'b010101, 4'b1110, 4'd0);  // CMP -> Flags=0110
    tick();
    drive(2'b01, 6'b000001, 4'b1110, 4'd4);  // LDR
    tick();
    bubble();
    tick();
    chk("ldr_regwrM", 8'(RegWriteM), 8'h1);
    chk("ldr_flags", 8'(Flags), 8'h6);
    RESET = 1'b0; StallE = 1'b1;
    drive(2'b01, 6'b000000, 4'b1110, 4'd4);  // STR in decode during reset
    #1;
    chk("rst_regsrcD", 8'(RegSrcD), 8'h2);
    chk("rst_immsrcD", 8'(ImmSrcD), 8'h1);
    tick();
    RESET = 1'b1; StallE = 1'b0;
    chk("rst_regwrW", 8'(RegWriteW), 8'h0);
    chk("rst_m2rW", 8'(MemtoRegW), 8'h0);
    chk("rst_flags_mid", 8'(Flags), 8'h0);
    chk("rst_aluc_mid", 8'(ALUControlE), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
